// File: rtl/stream_scoreboard.sv
// stream_scoreboard: in-order expected-vs-actual stream checker with counters, stall watchdog and first-mismatch capture
//   i_clk, i_rst_n (async, active-low), i_clear (sync clear, highest priority)
//   i_exp_valid/o_exp_ready/i_exp_data : expected-beat push into the FIFO
//   i_act_valid/i_act_data             : DUT beat, always accepted, compared against FIFO head
//   o_pending                          : FIFO occupancy
//   o_match/mismatch/underflow_count   : saturating 16-bit counters
//   o_timeout                          : sticky, expectations pending with no compare for TIMEOUT cycles
//   o_err_valid/o_err_exp/o_err_act    : first mismatch capture
//   o_idle                             : FIFO empty and watchdog idle
module stream_scoreboard #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear,
    input  logic                    i_exp_valid,
    output logic                    o_exp_ready,
    input  logic [DATA_W-1:0]       i_exp_data,
    input  logic                    i_act_valid,
    input  logic [DATA_W-1:0]       i_act_data,
    output logic [$clog2(DEPTH):0]  o_pending,
    output logic [15:0]             o_match_count,
    output logic [15:0]             o_mismatch_count,
    output logic [15:0]             o_underflow_count,
    output logic                    o_timeout,
    output logic                    o_err_valid,
    output logic [DATA_W-1:0]       o_err_exp,
    output logic [DATA_W-1:0]       o_err_act,
    output logic                    o_idle
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, TOUT} state_t;
    state_t            r_state;
    logic [WW-1:0]     r_wdog;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr, r_rd;
    logic [AW:0]       r_cnt;
    logic [15:0]       r_match, r_mism, r_under;
    logic              r_tout, r_errv;
    logic [DATA_W-1:0] r_eexp, r_eact;
    logic              w_push, w_pop, w_under, w_miss;
    logic [DATA_W-1:0] w_head;
    assign o_exp_ready       = r_cnt != FULL;
    assign w_push            = i_exp_valid && o_exp_ready;
    assign w_pop             = i_act_valid && r_cnt != '0;
    assign w_under           = i_act_valid && r_cnt == '0;
    assign w_head            = r_mem[r_rd];
    // Case inequality so an unknown DUT value is reported as a mismatch
    assign w_miss            = w_head !== i_act_data;
    assign o_pending         = r_cnt;
    assign o_match_count     = r_match;
    assign o_mismatch_count  = r_mism;
    assign o_underflow_count = r_under;
    assign o_timeout         = r_tout;
    assign o_err_valid       = r_errv;
    assign o_err_exp         = r_eexp;
    assign o_err_act         = r_eact;
    assign o_idle            = r_cnt == '0 && r_state == IDLE;
    // Storage needs no reset: the pointers define what is valid
    always_ff @(posedge i_clk)
        if (w_push) r_mem[r_wr] <= i_exp_data;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            {r_wr, r_rd, r_cnt, r_match, r_mism, r_under, r_errv, r_eexp, r_eact} <= '0;
        else if (i_clear)
            {r_wr, r_rd, r_cnt, r_match, r_mism, r_under, r_errv, r_eexp, r_eact} <= '0;
        else begin
            r_wr  <= r_wr + AW'(w_push);
            r_rd  <= r_rd + AW'(w_pop);
            r_cnt <= r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
            if (w_pop && !w_miss && r_match != 16'hFFFF) r_match <= r_match + 16'd1;
            if (w_pop && w_miss && r_mism != 16'hFFFF) r_mism <= r_mism + 16'd1;
            if (w_under && r_under != 16'hFFFF) r_under <= r_under + 16'd1;
            if (w_pop && w_miss && !r_errv) begin
                r_errv <= 1'b1;
                r_eexp <= w_head;
                r_eact <= i_act_data;
            end
        end
    // Stall watchdog: counts compare-free cycles while expectations are outstanding
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_wdog  <= '0;
            r_tout  <= 1'b0;
        end else if (i_clear) begin
            r_state <= IDLE;
            r_wdog  <= '0;
            r_tout  <= 1'b0;
        end else
            case (r_state)
                IDLE: begin
                    r_wdog <= '0;
                    if (r_cnt != '0) r_state <= WAIT;
                end
                WAIT:
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_wdog  <= '0;
                    end else if (w_pop)
                        r_wdog <= '0;
                    else if (r_wdog == WW'(TIMEOUT - 1)) begin
                        r_state <= TOUT;
                        r_tout  <= 1'b1;
                    end else
                        r_wdog <= r_wdog + WW'(1);
                default: r_tout <= 1'b1;
            endcase
endmodule

// File: tb/tb_stream_scoreboard.sv
// tb_stream_scoreboard: vector table, directed corner cases and random traffic against a queue-based model
module tb_stream_scoreboard;
    localparam int DW = 32, D = 8, TO = 10, PW = $clog2(D) + 1;
    logic clk = 0, rst_n = 0, clr = 0, ev = 0, av = 0;
    logic [DW-1:0] ed = 0, ad = 0;
    logic ready, tout, errv, idle;
    logic [PW-1:0] pend;
    logic [15:0] mcnt, mmcnt, ucnt;
    logic [DW-1:0] eexp, eact;
    stream_scoreboard #(.DATA_W(DW), .DEPTH(D), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr),
        .i_exp_valid(ev), .o_exp_ready(ready), .i_exp_data(ed),
        .i_act_valid(av), .i_act_data(ad), .o_pending(pend),
        .o_match_count(mcnt), .o_mismatch_count(mmcnt), .o_underflow_count(ucnt),
        .o_timeout(tout), .o_err_valid(errv), .o_err_exp(eexp), .o_err_act(eact),
        .o_idle(idle));
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    logic [DW-1:0] q[$];
    int m_match, m_mism, m_under, run, quiet;
    bit m_tout, m_errv, last_zero;
    logic [DW-1:0] m_eexp, m_eact;
    typedef struct {
        logic ev; logic [31:0] ed; logic av; logic [31:0] ad;
        int m, mm, pend; logic errv, idle;
    } vec_t;
    vec_t tbl[14];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask
    task automatic model_reset();
        q.delete();
        {m_match, m_mism, m_under, run, quiet} = '0;
        {m_tout, m_errv} = '0;
        {m_eexp, m_eact} = '0;
        last_zero = 1;
    endtask
    // One clock edge of the scoreboard rules, applied to the inputs present at the edge
    task automatic model_edge();
        int p;
        bit cmp;
        logic [DW-1:0] h;
        if (!rst_n || clr) begin
            model_reset();
            return;
        end
        p = q.size();
        cmp = av && p != 0;
        if (cmp) begin
            h = q.pop_front();
            if (h !== ad) begin
                if (m_mism < 65535) m_mism++;
                if (!m_errv) begin m_errv = 1; m_eexp = h; m_eact = ad; end
            end else if (m_match < 65535) m_match++;
        end
        if (av && p == 0 && m_under < 65535) m_under++;
        if (p == 0) begin run = 0; quiet = 0; end
        else begin
            quiet = (run == 0 || cmp) ? 0 : quiet + 1;
            run++;
            if (quiet == TO) m_tout = 1;
        end
        last_zero = p == 0;
        if (ev && p != D) q.push_back(ed);
    endtask
    task automatic cyc(input logic e, input logic [DW-1:0] d, input logic a, input logic [DW-1:0] x, input logic c = 0);
        ev = e; ed = d; av = a; ad = x; clr = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        ev = 0; av = 0; clr = 0;
    endtask
    task automatic check_all();
        chk("pending", pend, q.size());
        chk("exp_ready", ready, q.size() != D);
        chk("match", mcnt, m_match);
        chk("mismatch", mmcnt, m_mism);
        chk("underflow", ucnt, m_under);
        chk("timeout", tout, m_tout);
        chk("err_valid", errv, m_errv);
        chk("err_exp", eexp, m_eexp);
        chk("err_act", eact, m_eact);
        chk("idle", idle, q.size() == 0 && !m_tout && last_zero);
    endtask
    initial begin
        tbl = '{
            '{1, 32'h11, 0, 32'h0,  0, 0, 1, 0, 0},
            '{1, 32'h22, 0, 32'h0,  0, 0, 2, 0, 0},
            '{1, 32'h33, 0, 32'h0,  0, 0, 3, 0, 0},
            '{0, 32'h0,  1, 32'h11, 1, 0, 2, 0, 0},
            '{0, 32'h0,  1, 32'h22, 2, 0, 1, 0, 0},
            '{0, 32'h0,  1, 32'h33, 3, 0, 0, 0, 0},
            '{0, 32'h0,  0, 32'h0,  3, 0, 0, 0, 1},
            '{1, 32'hA,  0, 32'h0,  3, 0, 1, 0, 0},
            '{1, 32'hB,  0, 32'h0,  3, 0, 2, 0, 0},
            '{0, 32'h0,  1, 32'hA,  4, 0, 1, 0, 0},
            '{0, 32'h0,  1, 32'hC,  4, 1, 0, 1, 0},
            '{0, 32'h0,  1, 32'hB,  4, 1, 0, 1, 1},
            '{1, 32'hD,  0, 32'h0,  4, 1, 1, 1, 0},
            '{0, 32'h0,  1, 32'hE,  4, 2, 0, 1, 0}};
        model_reset();
        @(negedge clk); @(negedge clk);
        check_all();
        chk("reset_ready", ready, 1);
        rst_n = 1;
        @(negedge clk);
        foreach (tbl[i]) begin
            cyc(tbl[i].ev, tbl[i].ed, tbl[i].av, tbl[i].ad);
            chk($sformatf("tbl%0d_match", i), mcnt, tbl[i].m);
            chk($sformatf("tbl%0d_mismatch", i), mmcnt, tbl[i].mm);
            chk($sformatf("tbl%0d_pending", i), pend, tbl[i].pend);
            chk($sformatf("tbl%0d_errv", i), errv, tbl[i].errv);
            chk($sformatf("tbl%0d_idle", i), idle, tbl[i].idle);
            check_all();
        end
        chk("first_err_exp", eexp, 32'hB);
        chk("first_err_act", eact, 32'hC);
        chk("underflow_one", ucnt, 1);
        // Full FIFO, push+pop at D-1 and at full, then a 2*D wrap
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < D - 1; i++) cyc(1, 100 + i, 0, 0);
        cyc(1, 200, 1, 100);
        chk("pushpop_keeps", pend, D - 1);
        cyc(1, 201, 0, 0);
        chk("full_pending", pend, D);
        chk("full_ready", ready, 0);
        cyc(1, 300, 1, 101);
        chk("full_push_rejected", pend, D - 1);
        check_all();
        for (int i = 0; i < 2 * D; i++) begin cyc(1, 500 + i, 1, q[0]); check_all(); end
        while (q.size() != 0) cyc(0, 0, 1, q[0]);
        chk("wrap_mismatch", mmcnt, 0);
        chk("wrap_match", mcnt, 3 * D + 1);
        check_all();
        // Empty FIFO act with same-cycle push: no bypass
        cyc(0, 0, 0, 0, 1);
        cyc(1, 5, 1, 5);
        chk("nobypass_under", ucnt, 1);
        chk("nobypass_pending", pend, 1);
        chk("nobypass_match", mcnt, 0);
        // Watchdog timing
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'h77, 0, 0);
        for (int i = 1; i <= TO; i++) begin cyc(0, 0, 0, 0); chk("tout_early", tout, 0); end
        cyc(0, 0, 0, 0);
        chk("tout_set", tout, 1);
        cyc(0, 0, 1, 32'h77);
        chk("tout_match", mcnt, 1);
        chk("tout_sticky", tout, 1);
        check_all();
        cyc(1, 9, 1, 9, 1);
        chk("clear_match", mcnt, 0);
        chk("clear_tout", tout, 0);
        chk("clear_pending", pend, 0);
        check_all();
        // Unknown actual data is a mismatch
        cyc(1, 32'h5A5A5A5A, 0, 0);
        cyc(0, 0, 1, 'x);
        chk("x_mismatch", mmcnt, 1);
        check_all();
        // Randomized traffic
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 2) != 0,
                (q.size() != 0 && $urandom_range(0, 9) < 8) ? q[0] : $urandom,
                $urandom_range(0, 299) == 0);
            check_all();
        end
        // Underflow saturation
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 65540; i++) cyc(0, 0, 1, 0);
        chk("underflow_sat", ucnt, 16'hFFFF);
        check_all();
        // Asynchronous reset mid-stream
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 40 + i, 0, 0);
        chk("pre_reset_pending", pend, 5);
        #2 rst_n = 0;
        #1 model_reset();
        chk("async_pending", pend, 0);
        check_all();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
